// File: rtl/vote_argmax.sv
// Serial argmax over a captured vote vector, result offered by valid/ready.
// Optional ARGMAX_MARGIN_EN adds a best-minus-second-best margin output.
//
// Ports:
//   clock, reset    rising-edge clock, async active-high reset
//   vote_done       level "votes final" flag, triggers one run per assertion
//   VoteData        packed counts, class i at [i*bitlength +: bitlength]
//   result_ready    sink accepts the result while result_valid is high
//   result_valid    class_idx/max_votes/no_vote(/margin) are valid and stable
//   class_idx       winning class (lowest index on ties)
//   max_votes       vote count of the winning class
//   no_vote         every count was zero
//   busy            capture or scan in progress
//   margin          (ARGMAX_MARGIN_EN) best minus second-best count
module vote_argmax #(
  parameter int bitlength  = 12,
  parameter int output_dim = 10,
  parameter int idx_width  = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             vote_done,
  input  logic [output_dim*bitlength-1:0]  VoteData,
  input  logic                             result_ready,
  output logic                             result_valid,
  output logic [idx_width-1:0]             class_idx,
  output logic [bitlength-1:0]             max_votes,
  output logic                             no_vote,
`ifdef ARGMAX_MARGIN_EN
  output logic [bitlength-1:0]             margin,
`endif
  output logic                             busy
);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    SCAN,
    HOLD
  } state_t;

  localparam logic [idx_width-1:0] LAST =
    idx_width'(output_dim - 1);

  state_t               state;
  logic                 armed;
  logic [bitlength-1:0] snap [output_dim];
  logic [bitlength-1:0] best;
  logic [idx_width-1:0] best_idx;
  logic [idx_width-1:0] idx;
  logic [bitlength-1:0] cur;
`ifdef ARGMAX_MARGIN_EN
  logic [bitlength-1:0] second;
`endif

  assign cur  = snap[idx];
  assign busy = (state == CAPTURE) || (state == SCAN);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      armed        <= 1'b1;
      best         <= '0;
      best_idx     <= '0;
      idx          <= '0;
      result_valid <= 1'b0;
      class_idx    <= '0;
      max_votes    <= '0;
      no_vote      <= 1'b0;
      for (int i = 0; i < output_dim; i++)
        snap[i] <= '0;
`ifdef ARGMAX_MARGIN_EN
      second       <= '0;
      margin       <= '0;
`endif
    end else begin
      // A flag held high never re-triggers; it must drop first.
      if (!vote_done)
        armed <= 1'b1;

      unique case (state)
        IDLE: begin
          if (vote_done && armed) begin
            armed <= 1'b0;
            state <= CAPTURE;
          end
        end

        CAPTURE: begin
          for (int i = 0; i < output_dim; i++)
            snap[i] <= VoteData[i*bitlength +: bitlength];
          best     <= VoteData[0 +: bitlength];
          best_idx <= '0;
          idx      <= idx_width'(1);
`ifdef ARGMAX_MARGIN_EN
          second   <= '0;
`endif
          if (output_dim == 1)
            state <= HOLD;
          else
            state <= SCAN;
        end

        SCAN: begin
          // Strict compare keeps the lowest index on ties.
          if (cur > best) begin
            best     <= cur;
            best_idx <= idx;
`ifdef ARGMAX_MARGIN_EN
            second   <= best;
`endif
          end
`ifdef ARGMAX_MARGIN_EN
          // cur <= best here, so this also catches a tie with best.
          else if (cur > second) begin
            second <= cur;
          end
`endif
          idx <= idx + idx_width'(1);
          if (idx == LAST)
            state <= HOLD;
        end

        HOLD: begin
          // First HOLD cycle loads the fields; they then stay put
          // until the handshake completes.
          if (!result_valid) begin
            result_valid <= 1'b1;
            class_idx    <= best_idx;
            max_votes    <= best;
            no_vote      <= (best == '0);
`ifdef ARGMAX_MARGIN_EN
            margin       <= best - second;
`endif
          end else if (result_ready) begin
            result_valid <= 1'b0;
            state        <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vote_argmax.sv
// Table-driven bench for vote_argmax with a result scoreboard.
// Expected results are queued at trigger time and popped at each handshake.
module tb_vote_argmax;

  localparam int BL = 12;
  localparam int OD = 10;
  localparam int IW = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            vote_done = 1'b0;
  logic [OD*BL-1:0] VoteData = '0;
  logic            result_ready = 1'b0;
  logic            result_valid;
  logic [IW-1:0]   class_idx;
  logic [BL-1:0]   max_votes;
  logic            no_vote;
  logic            busy;
`ifdef ARGMAX_MARGIN_EN
  logic [BL-1:0]   margin;
`endif

  vote_argmax #(
    .bitlength (BL),
    .output_dim(OD),
    .idx_width (IW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .vote_done   (vote_done),
    .VoteData    (VoteData),
    .result_ready(result_ready),
    .result_valid(result_valid),
    .class_idx   (class_idx),
    .max_votes   (max_votes),
    .no_vote     (no_vote),
`ifdef ARGMAX_MARGIN_EN
    .margin      (margin),
`endif
    .busy        (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [OD*BL-1:0] data;
    int idx;
    int mx;
    int nov;
    int mar;
  } vec_t;

  typedef struct {
    int idx;
    int mx;
    int nov;
    int mar;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[7];
  int   n_checks = 0;
  int   n_fail = 0;
  int   hs = 0;
  int   lat;
  int   hs0;

  function automatic logic [OD*BL-1:0] pk(
    input int a0, input int a1, input int a2, input int a3,
    input int a4, input int a5, input int a6, input int a7,
    input int a8, input int a9);
    logic [OD*BL-1:0] r;
    int a[OD];
    a = '{a0, a1, a2, a3, a4, a5, a6, a7, a8, a9};
    r = '0;
    for (int i = 0; i < OD; i++)
      r[i*BL +: BL] = BL'(a[i]);
    return r;
  endfunction

  task automatic check(input string name, input int act,
                       input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int k);
    exp_t e;
    e.idx = tbl[k].idx;
    e.mx  = tbl[k].mx;
    e.nov = tbl[k].nov;
    e.mar = tbl[k].mar;
    sb.push_back(e);
  endtask

  // Scoreboard: compare every accepted result against the queue head.
  always @(negedge clock) begin
    if (!reset && result_valid && result_ready) begin
      hs++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got idx %0d, expected none",
                 class_idx);
      end else begin
        mon_e = sb.pop_front();
        check("class_idx", int'(class_idx), mon_e.idx);
        check("max_votes", int'(max_votes), mon_e.mx);
        check("no_vote", int'(no_vote), mon_e.nov);
`ifdef ARGMAX_MARGIN_EN
        check("margin", int'(margin), mon_e.mar);
`endif
      end
    end
  end

  // Called right after driving a trigger; lat = edges from the trigger
  // edge until result_valid is seen, or -1 on timeout.
  task automatic wait_valid(input bit keep, input bit scr,
                            output int l);
    l = -1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock);
      #1;
      if (!keep)
        vote_done = 1'b0;
      if (scr && c >= 1)
        VoteData = (OD*BL)'({$urandom, $urandom,
                             $urandom, $urandom});
      if (result_valid) begin
        l = c;
        return;
      end
    end
  endtask

  task automatic wait_hs(input int target, input string name);
    for (int c = 0; c < 60; c++) begin
      if (hs >= target)
        break;
      @(posedge clock);
      #1;
    end
    check(name, int'(hs >= target), 1);
  endtask

  initial begin
    tbl[0] = '{pk(3,0,7,1,0,0,2,0,0,5), 2, 7, 0, 2};
    tbl[1] = '{pk(1,1,1,1,9,1,1,1,9,1), 4, 9, 0, 0};
    tbl[2] = '{pk(0,0,0,0,0,0,0,0,0,0), 0, 0, 1, 0};
    tbl[3] = '{pk(0,0,0,4094,0,0,0,4095,0,0), 7, 4095, 0, 1};
    tbl[4] = '{pk(8,7,0,0,0,0,0,0,0,0), 0, 8, 0, 1};
    tbl[5] = '{pk(1,2,3,4,5,6,7,8,9,10), 9, 10, 0, 1};
    tbl[6] = '{pk(2,2,2,2,2,2,2,2,2,30), 9, 30, 0, 28};

    #1;
    check("rst_valid", int'(result_valid), 0);
    check("rst_idx", int'(class_idx), 0);
    check("rst_max", int'(max_votes), 0);
    check("rst_novote", int'(no_vote), 0);
    check("rst_busy", int'(busy), 0);
`ifdef ARGMAX_MARGIN_EN
    check("rst_margin", int'(margin), 0);
`endif
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    result_ready = 1'b1;

    // Table vectors, one full transaction each.
    for (int k = 0; k < 6; k++) begin
      @(posedge clock);
      #1;
      hs0 = hs;
      VoteData = tbl[k].data;
      push(k);
      vote_done = 1'b1;
      wait_valid(1'b0, 1'b0, lat);
      check("latency", lat, OD + 1);
      wait_hs(hs0 + 1, "handshake");
      check("valid_drop", int'(result_valid), 0);
    end

    // Backpressure with VoteData scrambled during SCAN and HOLD.
    @(posedge clock);
    #1;
    result_ready = 1'b0;
    hs0 = hs;
    VoteData = tbl[0].data;
    push(0);
    vote_done = 1'b1;
    wait_valid(1'b0, 1'b1, lat);
    check("bp_latency", lat, OD + 1);
    for (int c = 0; c < 20; c++) begin
      @(posedge clock);
      #1;
      VoteData = (OD*BL)'({$urandom, $urandom, $urandom, $urandom});
      check("bp_valid", int'(result_valid), 1);
      check("bp_idx", int'(class_idx), 2);
      check("bp_max", int'(max_votes), 7);
    end
    check("bp_no_transfer", hs, hs0);
    result_ready = 1'b1;
    wait_hs(hs0 + 1, "bp_handshake");
    check("bp_valid_drop", int'(result_valid), 0);
    check("bp_idle", int'(busy), 0);
    check("bp_single", hs, hs0 + 1);

    // Flag held high: one result only; re-arm after a 1-cycle drop.
    @(posedge clock);
    #1;
    hs0 = hs;
    VoteData = tbl[0].data;
    push(0);
    vote_done = 1'b1;
    repeat (50) @(posedge clock);
    #1;
    check("held_one_result", hs, hs0 + 1);
    vote_done = 1'b0;
    @(posedge clock);
    #1;
    VoteData = tbl[6].data;
    push(6);
    vote_done = 1'b1;
    wait_hs(hs0 + 2, "rearm_result");
    repeat (5) @(posedge clock);
    #1;
    check("no_retrigger", hs, hs0 + 2);

    // Reset during SCAN, then a fresh run with the flag still high.
    vote_done = 1'b0;
    @(posedge clock);
    #1;
    VoteData = tbl[3].data;
    push(3);
    vote_done = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    check("scan_busy", int'(busy), 1);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", int'(result_valid), 0);
    check("mid_rst_idx", int'(class_idx), 0);
    check("mid_rst_max", int'(max_votes), 0);
    check("mid_rst_novote", int'(no_vote), 0);
    check("mid_rst_busy", int'(busy), 0);
    sb.delete();
    repeat (2) @(posedge clock);
    #1;
    hs0 = hs;
    push(3);
    reset = 1'b0;
    wait_valid(1'b1, 1'b0, lat);
    check("post_rst_latency", lat, OD + 1);
    wait_hs(hs0 + 1, "post_rst_result");
    vote_done = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vote_argmax.md
Name: vote_argmax

Overview:
- Downstream stage of the top-level RBM inference wrapper.
- Consumes its per-class vote-count vector when its level-high finish flag rises, then scans the classes serially, one per cycle, to find the winning class.
- Presents the winning class index and its vote count through a valid/ready handshake to the result sink (host interface or scoreboard).

Parameters:
- bitlength, 12, width of each unsigned vote count
- output_dim, 10, number of classes in the vote vector
- idx_width, 4, width of class index; must satisfy 2^idx_width >= output_dim

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- vote_done  input  1  level-high "votes final" flag from the upstream finish output
- VoteData  input  output_dim*bitlength  packed vote counts; class i at bits [i*bitlength +: bitlength]
- result_ready  input  1  sink accepts the result while result_valid is high
- result_valid  output  1  result fields are valid and held stable
- class_idx  output  idx_width  winning class index
- max_votes  output  bitlength  vote count of the winning class
- no_vote  output  1  all counts were zero
- busy  output  1  high in CAPTURE or SCAN

Behaviour:
- Reset (async, any state): state=IDLE, armed=1, all outputs 0, internal snapshot and scan registers 0.
- States: IDLE, CAPTURE, SCAN, HOLD.
- IDLE:
  - Go to CAPTURE when vote_done=1 and armed=1.
  - Clear armed on that transition.
- Re-arm:
  - armed is set again on any cycle in which vote_done=0.
  - A flag held high across a whole transaction therefore never triggers a second run.
- CAPTURE (1 cycle):
  - Snapshot VoteData into an internal register.
  - Set best_idx=0, best=snapshot[0], idx=1.
  - Go to SCAN; if output_dim==1, go directly to HOLD.
  - VoteData changes after this cycle have no effect.
- SCAN (output_dim-1 cycles):
  - Each cycle compares snapshot[idx] > best, unsigned and strict.
  - If greater, update best and best_idx.
  - idx increments; after idx==output_dim-1 is evaluated, go to HOLD.
  - Strict compare means ties resolve to the lowest index.
- HOLD:
  - On entry, register class_idx=best_idx, max_votes=best, no_vote=(best==0), and assert result_valid.
  - Fields stay stable while result_valid=1.
  - On a cycle with result_valid=1 and result_ready=1: deassert result_valid next edge, return to IDLE.
  - result_ready high before HOLD is entered has no effect. No combinational ready-to-valid path.
- Latency: trigger edge to result_valid high = output_dim+1 cycles (11 at defaults).
- Throughput: one result per trigger. A trigger while not in IDLE is not lost if vote_done is still high and armed=1 when IDLE is re-entered; otherwise it is dropped.
- Outputs keep their last values after the handshake until the next HOLD entry. No_vote is valid only while result_valid=1.
- All-zero votes: class_idx=0, max_votes=0, no_vote=1.
- Saturated count 2^bitlength-1 compares normally; no arithmetic overflow is possible.
- busy = (state==CAPTURE or state==SCAN).

Optional Feature:
- Macro: ARGMAX_MARGIN_EN
- Defined:
  - Adds output port margin (bitlength) and tracks a second-best count during SCAN.
  - If a new max is found, the old best becomes second.
  - Else if snapshot[idx] > second, second is updated.
  - A tie with best also updates second (compare is >= against best for this purpose only).
  - margin = best - second, registered with the other fields on HOLD entry.
  - margin = 0 on a tie or all-zero input; margin = max_votes when output_dim==1.
  - margin resets to 0.
- Not defined: no margin port, no second-best logic; all other behaviour is identical.

Test Plan:
- Votes {3,0,7,1,0,0,2,0,0,5}, vote_done rises, result_ready=1 -> result_valid high exactly 11 cycles after trigger; class_idx=2, max_votes=7, no_vote=0; with ARGMAX_MARGIN_EN, margin=2.
- Votes class4=9 and class8=9, rest 1 -> class_idx=4, max_votes=9; margin=0 when enabled.
- All counts 0 -> class_idx=0, max_votes=0, no_vote=1.
- result_ready held 0 for 20 cycles after valid, VoteData changed during SCAN and HOLD -> fields stable and equal to the captured snapshot; single transfer when ready rises; state returns to IDLE.
- vote_done held high for 50 cycles -> exactly one result. Drop vote_done for 1 cycle, raise it with new votes (class9=30) -> second result with class_idx=9.
- Assert reset during SCAN (cycle 5 after trigger) -> all outputs 0 immediately. After release with vote_done still high, a full fresh run produces the correct result.
